// File: rtl/shifter_pkg.sv
// Shared encodings for the shifter sequencer: opcodes, shifter modes and FSM states.
// Latency/backpressure: n/a (constants only).
package shifter_pkg;

  localparam logic [2:0] CMD_LOAD = 3'b000;
  localparam logic [2:0] CMD_SHL  = 3'b001;
  localparam logic [2:0] CMD_SHR  = 3'b010;
  localparam logic [2:0] CMD_ROL  = 3'b011;
  localparam logic [2:0] CMD_ROR  = 3'b100;

  // Mode is {select2, select1} as seen by the parallel-load shifter.
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_MSB  = 2'b10;
  localparam logic [1:0] MODE_LSB  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/shifter_sequencer_if.sv
// Command/control bundle between the sequencer (master) and its environment plus shifter (slave).
// No storage; the master modport is the sequencer side.
interface shifter_sequencer_if #(
  parameter int BUS_WIDTH = 8,
  parameter int CNT_WIDTH = $clog2(BUS_WIDTH) + 1
);
  logic                 start_i;
  logic [2:0]           cmd_i;
  logic [CNT_WIDTH-1:0] count_i;
  logic                 fill_i;
  logic [BUS_WIDTH-1:0] load_data_i;
  logic                 abort_i;
  logic [BUS_WIDTH-1:0] shifter_q_i;
  logic                 select1_o;
  logic                 select2_o;
  logic                 dataR_o;
  logic                 dataL_o;
  logic [BUS_WIDTH-1:0] data_o;
  logic                 busy_o;
  logic                 done_o;

  modport master (
    input  start_i, cmd_i, count_i, fill_i, load_data_i, abort_i, shifter_q_i,
    output select1_o, select2_o, dataR_o, dataL_o, data_o, busy_o, done_o
  );

  modport slave (
    output start_i, cmd_i, count_i, fill_i, load_data_i, abort_i, shifter_q_i,
    input  select1_o, select2_o, dataR_o, dataL_o, data_o, busy_o, done_o
  );
endinterface

// File: rtl/shifter_sequencer.sv
// Sequences LOAD/SHL/SHR/ROL/ROR on an external shifter; one mode cycle per step, DONE one cycle after.
// start_i is sampled only in IDLE (no queuing); abort_i cancels LOAD/SHIFT without a done pulse.
module shifter_sequencer
  import shifter_pkg::*;
#(
  parameter int BUS_WIDTH = 8,
  parameter int CNT_WIDTH = $clog2(BUS_WIDTH) + 1
) (
  input  logic                clk,
  input  logic                rst_i,
  shifter_sequencer_if.master bus
);

  localparam logic [CNT_WIDTH-1:0] LP_MAX_STEPS = CNT_WIDTH'(BUS_WIDTH);

  state_e               r_state;
  logic [2:0]           r_cmd;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_fill;
  logic [BUS_WIDTH-1:0] r_data;
  logic [1:0]           r_mode;
  logic                 r_busy;
  logic                 r_done;

  logic [CNT_WIDTH-1:0] w_steps;
  logic                 w_is_shift;
  logic                 w_toward_msb;

  always_comb begin
    w_steps      = (bus.count_i > LP_MAX_STEPS) ? LP_MAX_STEPS : bus.count_i;
    w_is_shift   = (bus.cmd_i == CMD_SHL) || (bus.cmd_i == CMD_SHR) ||
                   (bus.cmd_i == CMD_ROL) || (bus.cmd_i == CMD_ROR);
    w_toward_msb = (bus.cmd_i == CMD_SHL) || (bus.cmd_i == CMD_ROL);
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cmd   <= '0;
      r_cnt   <= '0;
      r_fill  <= 1'b0;
      r_data  <= '0;
      r_mode  <= MODE_HOLD;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start_i) begin
            r_cmd  <= bus.cmd_i;
            r_fill <= bus.fill_i;
            r_data <= bus.load_data_i;
            r_cnt  <= w_steps;
            if (bus.cmd_i == CMD_LOAD) begin
              r_state <= ST_LOAD;
              r_mode  <= MODE_LOAD;
              r_busy  <= 1'b1;
            end else if (w_is_shift && (w_steps != '0)) begin
              r_state <= ST_SHIFT;
              r_mode  <= w_toward_msb ? MODE_MSB : MODE_LSB;
              r_busy  <= 1'b1;
            end else begin
              // Zero-count shifts and NOPs complete without touching the shifter.
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          r_mode  <= MODE_HOLD;
          r_busy  <= 1'b0;
          r_state <= bus.abort_i ? ST_IDLE : ST_DONE;
          r_done  <= !bus.abort_i;
        end
        ST_SHIFT: begin
          r_cnt <= r_cnt - 1'b1;
          // Leave on the last step so the mode drops exactly after N shift cycles.
          if (bus.abort_i || (r_cnt == CNT_WIDTH'(1))) begin
            r_mode  <= MODE_HOLD;
            r_busy  <= 1'b0;
            r_state <= bus.abort_i ? ST_IDLE : ST_DONE;
            r_done  <= !bus.abort_i;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.select1_o = r_mode[0];
  assign bus.select2_o = r_mode[1];
  assign bus.busy_o    = r_busy;
  assign bus.done_o    = r_done;
  assign bus.data_o    = r_data;

  // Rotates take the wrap-around bit straight from the live shifter contents.
  always_comb begin
    bus.dataR_o = 1'b0;
    bus.dataL_o = 1'b0;
    if (r_state == ST_SHIFT) begin
      if (r_cmd == CMD_SHL) bus.dataR_o = r_fill;
      if (r_cmd == CMD_ROL) bus.dataR_o = bus.shifter_q_i[BUS_WIDTH-1];
      if (r_cmd == CMD_SHR) bus.dataL_o = r_fill;
      if (r_cmd == CMD_ROR) bus.dataL_o = bus.shifter_q_i[0];
    end
  end

endmodule

// File: doc/shifter_sequencer.md
SHIFTER_SEQUENCER -- requirements
Module: shifter_sequencer

Interface
REQ-001 Parameter BUS_WIDTH, default 8, is the width of the controlled shifter.
REQ-002 Parameter CNT_WIDTH, default $clog2(BUS_WIDTH)+1, is the width of the shift-count field.
REQ-003 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 Port rst_i  input  1  is the asynchronous, active-high reset.
REQ-005 Port start_i  input  1  is the command request, sampled only while idle.
REQ-006 Port cmd_i  input  3  is the opcode: 000 LOAD, 001 SHL, 010 SHR, 011 ROL, 100 ROR; 101-111 NOP.
REQ-007 Port count_i  input  CNT_WIDTH  is the number of shift steps.
REQ-008 Port fill_i  input  1  is the serial fill bit for SHL/SHR.
REQ-009 Port load_data_i  input  BUS_WIDTH  is the parallel-load value.
REQ-010 Port abort_i  input  1  cancels an operation in progress.
REQ-011 Port shifter_q_i  input  BUS_WIDTH  is the shifter register contents, fed back.
REQ-012 Ports select1_o, select2_o  output  1 each  form the shifter mode {select2_o, select1_o}: 00 hold, 01 load, 10 shift toward MSB, 11 shift toward LSB.
REQ-013 Port dataR_o  output  1  is the bit entering the LSB on a shift toward the MSB.
REQ-014 Port dataL_o  output  1  is the bit entering the MSB on a shift toward the LSB.
REQ-015 Port data_o  output  BUS_WIDTH  is the parallel-load value presented to the shifter.
REQ-016 Port busy_o  output  1  is high while a command is executing.
REQ-017 Port done_o  output  1  is a one-cycle completion pulse.

Function
REQ-018 The FSM has states IDLE, LOAD, SHIFT and DONE.
REQ-019 start_i is accepted only in IDLE; on acceptance, cmd_i, count_i, fill_i and load_data_i are latched.
REQ-020 start_i is ignored outside IDLE, with no queuing.
REQ-021 LOAD command: IDLE->LOAD; mode 01 for exactly one cycle; data_o = latched value; then DONE.
REQ-022 SHL/ROL: IDLE->SHIFT with mode 10 for exactly N cycles, where N = min(count, BUS_WIDTH); then DONE.
REQ-023 SHR/ROR: same as REQ-022 with mode 11.
REQ-024 SHL drives dataR_o = latched fill; ROL drives dataR_o = shifter_q_i[BUS_WIDTH-1] combinationally.
REQ-025 SHR drives dataL_o = latched fill; ROR drives dataL_o = shifter_q_i[0] combinationally.
REQ-026 Inactive serial outputs are 0.
REQ-027 count = 0 for a shift or rotate, and any NOP opcode: IDLE->DONE directly, mode 00, shifter untouched.
REQ-028 count > BUS_WIDTH is clamped to BUS_WIDTH.
REQ-029 The remaining-step counter decrements once per SHIFT cycle; the FSM leaves SHIFT in the cycle the counter reaches its last step, with no extra shift.
REQ-030 abort_i high in LOAD or SHIFT: next state IDLE, mode 00 from the next cycle, no done_o pulse; shifts already applied remain.
REQ-031 abort_i is ignored in IDLE and DONE.
REQ-032 DONE lasts exactly one cycle with done_o = 1 and busy_o = 0, then returns to IDLE.
REQ-033 A new start is accepted no earlier than the cycle after DONE.
REQ-034 busy_o = 1 exactly in LOAD and SHIFT.
REQ-035 Mode is 00 in IDLE and DONE.
REQ-036 Select, busy and done outputs are registered; dataR_o and dataL_o follow REQ-024 and REQ-025.

Reset
REQ-037 rst_i asynchronously forces IDLE, mode 00, all counters and latched fields 0, data_o 0, busy_o 0, done_o 0.
REQ-038 Reset mid-operation abandons the command immediately, with no done_o pulse.
REQ-039 The first start is accepted on the first rising edge after rst_i deasserts.

Structure
REQ-040 Opcode constants, mode encodings and FSM state encodings reside in a shared package, shifter_pkg.
REQ-041 The block is a single FSM module with no sub-module; the bench instantiates the existing 8-bit parallel-load shifter and closes the shifter_q_i loop.

Verification
REQ-042 LOAD with load_data_i = 8'hA5 -> busy_o for 1 cycle, done_o on the next cycle, shifter = 8'hA5.
REQ-043 LOAD 8'h81, then SHL count 3 with fill 1 -> 3 cycles of mode 10, then done_o, shifter = 8'h0F.
REQ-044 LOAD 8'h81, then ROR count 1 -> shifter = 8'hC0; then ROL count 8 -> shifter = 8'hC0 after 8 shift cycles.
REQ-045 SHR count 12 with fill 0 -> clamped to 8 cycles; shifter = 8'h00.
REQ-046 SHL count 0, and opcode 111 -> each gives done_o one cycle after acceptance, no mode change; start_i held high during busy is not re-accepted.
REQ-047 SHL count 6, abort_i asserted after the 2nd shift cycle -> IDLE, no done_o, exactly 2 shifts applied; repeat with rst_i instead -> all outputs 0 asynchronously.
